// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, frame
// constants and the clock-to-baud divider helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clock cycles per serial bit; callers guarantee an integer ratio of at least 2.
    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: loads a byte when start is offered in IDLE or at the end
// of a stop bit, then shifts it out LSB-first behind a start bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e       state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // tx_d is derived from the next state so the line changes on the same edge
    // as the state register, keeping tx a clean flop output.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        done      = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = ST_START;
                    shift_d = data;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    done = 1'b1;
                    if (start) begin
                        state_d = ST_START;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small FIFO of host bytes drained by the
// serializer, with back-to-back frames whenever the FIFO stays non-empty.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int ADDR_WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] w_data,
    input  logic       push,
    output logic       full,
    output logic       empty,
    output logic       tx,
    output logic       tx_busy
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int CNT_W      = ADDR_WIDTH + 1;

    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  push_ok;
    logic                  pop;
    logic                  ser_busy;
    logic                  ser_done;

    // Accept/pop decisions look only at the registered flags, so a push into a
    // full FIFO is dropped even when a pop frees a slot on the same edge.
    assign push_ok = push && !full_q;
    assign pop     = !empty_q && (!ser_busy || ser_done);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= w_data;
    end

    uart_tx_serializer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_serializer (
        .clk   (clk),
        .rst   (rst),
        .start (!empty_q),
        .data  (mem_q[rd_ptr_q]),
        .tx    (tx),
        .busy  (ser_busy),
        .done  (ser_done)
    );

    assign full    = full_q;
    assign empty   = empty_q;
    assign tx_busy = ser_busy;

endmodule
